// File: rtl/pa_fpu_wb_sched_pkg.sv
// Shared definitions for the FPU write-back slot scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pa_fpu_wb_sched_pkg;

  // Instruction-id width, matching the dp_xx_ex1_id format.
  localparam int FPU_ID_W = 3;

  // FMAU write-back latency encodings, counted in cycles from EX1 grant.
  localparam int FMAU_LAT3 = 3;
  localparam int FMAU_LAT4 = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/pa_fpu_wb_slot.sv
// One write-back reservation slot: a valid bit plus the id that will retire in it.
// Latency: one cycle per shift step; load/clear take effect on the next edge.
// Backpressure: hold freezes the slot contents.
// Ports: shift_vld/shift_id come from the next-older slot, load/load_id insert a
// newly granted op, clr kills the value being shifted in, slot_vld/slot_id are the
// current contents.
module pa_fpu_wb_slot #(
  parameter int ID_W = 3
) (
  input  logic            forever_cpuclk,
  input  logic            cpurst_b,
  input  logic            hold,
  input  logic            shift_vld,
  input  logic [ID_W-1:0] shift_id,
  input  logic            load,
  input  logic [ID_W-1:0] load_id,
  input  logic            clr,
  output logic            slot_vld,
  output logic [ID_W-1:0] slot_id
);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      slot_vld <= 1'b0;
      slot_id  <= '0;
    end else if (!hold) begin
      if (load) begin
        slot_vld <= 1'b1;
        slot_id  <= load_id;
      end else begin
        // clr only ever targets an op moving down from the older slot.
        slot_vld <= shift_vld & ~clr;
        slot_id  <= shift_id;
      end
    end
  end

endmodule

// File: rtl/pa_fpu_wb_sched.sv
// FPU register-file write-port scheduler: FMAU ops reserve their write-back slot
// at EX1 issue; divider results fill free cycles, with issue blocking so they never starve.
// Latency: grants are combinational; a granted op writes back 3 or 4 cycles later.
// Backpressure: sched_issue_grant=0 stalls upstream issue; div_wb_req is held until granted;
// sched_stall freezes all state and suppresses grants and write-back.
// Ports: ex1_issue_* (FMAU issue request), ex2_cancel (kill last grant), div_wb_* (divider
// result), sched_* outputs (grants, write-port valid/source/id, busy).
module pa_fpu_wb_sched
  import pa_fpu_wb_sched_pkg::*;
#(
  parameter int LAT_MAX = 4,
  parameter int ID_W    = FPU_ID_W
) (
  input  logic            forever_cpuclk,
  input  logic            cpurst_b,
  input  logic            ex1_issue_vld,
  input  logic            ex1_issue_lat4,
  input  logic [ID_W-1:0] ex1_issue_id,
  input  logic            ex2_cancel,
  input  logic            sched_stall,
  input  logic            div_wb_req,
  input  logic [ID_W-1:0] div_wb_id,
  output logic            sched_issue_grant,
  output logic            div_wb_grant,
  output logic            sched_wb_vld,
  output logic            sched_wb_src_div,
  output logic [ID_W-1:0] sched_wb_id,
  output logic            sched_busy
);

  localparam int IDX_W = $clog2(LAT_MAX + 1);

  // resv[i]: the FMAU writes back i cycles from now; rid[i] is that op's id.
  logic [LAT_MAX:0] resv;
  logic [ID_W-1:0]  rid [LAT_MAX:0];

  logic [IDX_W-1:0] issue_lat;
  logic [IDX_W-1:0] last_clr_idx;
  logic             issue_grant_c;
  logic             div_grant_c;
  logic             cancel_vld;
  logic             fsm_idle;
  logic             last_vld;
  logic             last_lat4;

  sched_state_e state, state_n;

  always_comb begin
    issue_lat     = ex1_issue_lat4 ? IDX_W'(FMAU_LAT4) : IDX_W'(FMAU_LAT3);
    // By the cancel cycle the last grant has already shifted down one slot,
    // so the value to drop is the one landing in slot (lat-2).
    last_clr_idx  = last_lat4 ? IDX_W'(FMAU_LAT4 - 2) : IDX_W'(FMAU_LAT3 - 2);
    // The grant check uses registered resv, so a slot cancelled this cycle
    // still looks busy until the next one.
    issue_grant_c = ex1_issue_vld & ~sched_stall & ~resv[issue_lat] & fsm_idle;
    div_grant_c   = div_wb_req & ~resv[0] & ~sched_stall;
    cancel_vld    = ex2_cancel & last_vld & ~sched_stall;
  end

  for (genvar g = 0; g <= LAT_MAX; g++) begin : g_slot
    logic            nxt_vld;
    logic [ID_W-1:0] nxt_id;

    if (g < LAT_MAX) begin : g_mid
      assign nxt_vld = resv[g+1];
      assign nxt_id  = rid[g+1];
    end else begin : g_top
      assign nxt_vld = 1'b0;
      assign nxt_id  = '0;
    end

    pa_fpu_wb_slot #(.ID_W(ID_W)) u_slot (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .hold           (sched_stall),
      .shift_vld      (nxt_vld),
      .shift_id       (nxt_id),
      .load           (issue_grant_c & (issue_lat == IDX_W'(g + 1))),
      .load_id        (ex1_issue_id),
      .clr            (cancel_vld & (last_clr_idx == IDX_W'(g))),
      .slot_vld       (resv[g]),
      .slot_id        (rid[g])
    );
  end

  // Remember the last unstalled cycle's grant so ex2_cancel knows what to kill.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      last_vld  <= 1'b0;
      last_lat4 <= 1'b0;
    end else if (!sched_stall) begin
      last_vld  <= issue_grant_c;
      last_lat4 <= ex1_issue_lat4;
    end
  end

  // FSM: state register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM: next state. A denied divider request blocks issue until the
  // reserved slots drain and the divider gets the port.
  always_comb begin
    state_n = state;
    if (!sched_stall) begin
      case (state)
        IDLE:     if (div_wb_req && !div_grant_c) state_n = DIV_WAIT;
        DIV_WAIT: if (div_grant_c)                state_n = IDLE;
        default:                                  state_n = IDLE;
      endcase
    end
  end

  // FSM: outputs and write-port mux.
  always_comb begin
    fsm_idle          = (state == IDLE);
    sched_issue_grant = issue_grant_c;
    div_wb_grant      = div_grant_c;
    sched_wb_vld      = ~sched_stall & (resv[0] | div_grant_c);
    sched_wb_src_div  = div_grant_c;
    sched_wb_id       = '0;
    if (!sched_stall) begin
      if (resv[0]) begin
        sched_wb_id = rid[0];
      end else if (div_grant_c) begin
        sched_wb_id = div_wb_id;
      end
    end
    sched_busy = (|resv) | (state == DIV_WAIT) | div_wb_req;
  end

endmodule

// File: tb/tb_pa_fpu_wb_sched.sv
module tb_pa_fpu_wb_sched;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       ex1_issue_vld;
  logic       ex1_issue_lat4;
  logic [2:0] ex1_issue_id;
  logic       ex2_cancel;
  logic       sched_stall;
  logic       div_wb_req;
  logic [2:0] div_wb_id;
  logic       sched_issue_grant;
  logic       div_wb_grant;
  logic       sched_wb_vld;
  logic       sched_wb_src_div;
  logic [2:0] sched_wb_id;
  logic       sched_busy;

  always #5 clk = ~clk;

  pa_fpu_wb_sched dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_b),
    .ex1_issue_vld     (ex1_issue_vld),
    .ex1_issue_lat4    (ex1_issue_lat4),
    .ex1_issue_id      (ex1_issue_id),
    .ex2_cancel        (ex2_cancel),
    .sched_stall       (sched_stall),
    .div_wb_req        (div_wb_req),
    .div_wb_id         (div_wb_id),
    .sched_issue_grant (sched_issue_grant),
    .div_wb_grant      (div_wb_grant),
    .sched_wb_vld      (sched_wb_vld),
    .sched_wb_src_div  (sched_wb_src_div),
    .sched_wb_id       (sched_wb_id),
    .sched_busy        (sched_busy)
  );

  // One row per cycle: inputs plus hand-derived grant/busy expectations.
  // eb: 0/1 expected busy, 2 = not checked.
  typedef struct {
    bit       iv;
    bit       l4;
    bit [2:0] iid;
    bit       cxl;
    bit       dreq;
    bit [2:0] did;
    bit       eg;
    bit       edg;
    bit [1:0] eb;
  } vec_t;

  typedef struct {
    int       due;
    bit [2:0] id;
  } wb_t;

  vec_t vecs[$];
  wb_t  sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic add(input bit iv, input bit l4, input bit [2:0] iid, input bit cxl,
                     input bit dreq, input bit [2:0] did, input bit eg, input bit edg,
                     input bit [1:0] eb);
    vec_t v;
    v.iv = iv; v.l4 = l4; v.iid = iid; v.cxl = cxl; v.dreq = dreq;
    v.did = did; v.eg = eg; v.edg = edg; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input bit [1:0] eb);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, eb);
  endtask

  task automatic drive_idle();
    ex1_issue_vld = 0; ex1_issue_lat4 = 0; ex1_issue_id = 0; ex2_cancel = 0;
    sched_stall = 0; div_wb_req = 0; div_wb_id = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit prev_eg;
    int hit;

    // Rows 0-4: single lat3 issue, write-back 3 cycles later.
    add(1, 0, 3'd2, 0, 0, 3'd0, 1, 0, 0);
    idle_row(1); idle_row(1); idle_row(1); idle_row(0);
    // Rows 5-11: lat4 then lat3 collision; lat3 denied once, then granted.
    add(1, 1, 3'd1, 0, 0, 3'd0, 1, 0, 0);
    add(1, 0, 3'd3, 0, 0, 3'd0, 0, 0, 1);
    add(1, 0, 3'd3, 0, 0, 3'd0, 1, 0, 1);
    idle_row(1); idle_row(1); idle_row(1); idle_row(0);
    // Rows 12-18: lat4 cancelled next cycle; same-cycle lat3 denied, next one granted.
    add(1, 1, 3'd5, 0, 0, 3'd0, 1, 0, 0);
    add(1, 0, 3'd4, 1, 0, 3'd0, 0, 0, 1);
    add(1, 0, 3'd4, 0, 0, 3'd0, 1, 0, 0);
    idle_row(1); idle_row(1); idle_row(1); idle_row(0);
    // Rows 19-22: cancel with no previous grant is ignored.
    add(1, 0, 3'd7, 1, 0, 3'd0, 1, 0, 0);
    idle_row(1); idle_row(1); idle_row(1);
    // Rows 23-31: back-to-back lat4, then a lat3 that collides once.
    add(1, 1, 3'd1, 0, 0, 3'd0, 1, 0, 0);
    add(1, 1, 3'd2, 0, 0, 3'd0, 1, 0, 1);
    add(1, 1, 3'd3, 0, 0, 3'd0, 1, 0, 1);
    add(1, 0, 3'd4, 0, 0, 3'd0, 0, 0, 1);
    add(1, 0, 3'd4, 0, 0, 3'd0, 1, 0, 1);
    idle_row(1); idle_row(1); idle_row(1); idle_row(0);
    // Rows 32-33: divider on an empty port is granted at once.
    add(0, 0, 3'd0, 0, 1, 3'd6, 0, 1, 2);
    idle_row(0);
    // Rows 34-45: continuous lat3 issue; divider raised at 39 waits for the
    // four reserved slots, is granted at 43, issue resumes at 44.
    for (int c = 34; c <= 45; c++) begin
      add(1, 0, 3'(c), 0, (c >= 39 && c <= 43), 3'd6, (c <= 39 || c >= 44), (c == 43),
          (c == 34 || c == 44) ? 2'd0 : 2'd1);
    end
    idle_row(1); idle_row(1); idle_row(1); idle_row(0);

    // Reset state.
    drive_idle();
    rst_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(sched_issue_grant), 0);
    chk("rst_div_grant", 32'(div_wb_grant), 0);
    chk("rst_wb_vld", 32'(sched_wb_vld), 0);
    chk("rst_src_div", 32'(sched_wb_src_div), 0);
    chk("rst_wb_id", 32'(sched_wb_id), 0);
    chk("rst_busy", 32'(sched_busy), 0);
    rst_b = 1;

    // Table-driven run with a write-back scoreboard.
    prev_eg = 0;
    for (int c = 0; c < vecs.size(); c++) begin
      step();
      ex1_issue_vld  = vecs[c].iv;
      ex1_issue_lat4 = vecs[c].l4;
      ex1_issue_id   = vecs[c].iid;
      ex2_cancel     = vecs[c].cxl;
      div_wb_req     = vecs[c].dreq;
      div_wb_id      = vecs[c].did;
      if (vecs[c].cxl && prev_eg && sb.size() > 0) void'(sb.pop_back());
      if (vecs[c].eg) sb.push_back('{due: c + (vecs[c].l4 ? 4 : 3), id: vecs[c].iid});
      prev_eg = vecs[c].eg;
      @(negedge clk);
      chk($sformatf("grant[%0d]", c), 32'(sched_issue_grant), 32'(vecs[c].eg));
      chk($sformatf("div_grant[%0d]", c), 32'(div_wb_grant), 32'(vecs[c].edg));
      if (vecs[c].eb != 2'd2) chk($sformatf("busy[%0d]", c), 32'(sched_busy), 32'(vecs[c].eb));
      hit = -1;
      foreach (sb[k]) if (sb[k].due == c) hit = k;
      if (hit >= 0) begin
        chk($sformatf("wb_vld[%0d]", c), 32'(sched_wb_vld), 1);
        chk($sformatf("wb_src[%0d]", c), 32'(sched_wb_src_div), 0);
        chk($sformatf("wb_id[%0d]", c), 32'(sched_wb_id), 32'(sb[hit].id));
        sb.delete(hit);
      end else if (vecs[c].edg) begin
        chk($sformatf("wb_vld[%0d]", c), 32'(sched_wb_vld), 1);
        chk($sformatf("wb_src[%0d]", c), 32'(sched_wb_src_div), 1);
        chk($sformatf("wb_id[%0d]", c), 32'(sched_wb_id), 32'(vecs[c].did));
      end else begin
        chk($sformatf("wb_idle[%0d]", c), 32'(sched_wb_vld), 0);
      end
    end
    chk("sb_drained", 32'(sb.size()), 0);

    // Stall while a write-back is due: held for two cycles, then emitted.
    step(); drive_idle();
    ex1_issue_vld = 1; ex1_issue_id = 3'd5;
    @(negedge clk); chk("stl_grant", 32'(sched_issue_grant), 1);
    step(); drive_idle();
    step();
    step();
    sched_stall = 1; ex1_issue_vld = 1; ex1_issue_lat4 = 1; ex1_issue_id = 3'd1;
    @(negedge clk);
    chk("stl_wb0", 32'(sched_wb_vld), 0);
    chk("stl_nogrant", 32'(sched_issue_grant), 0);
    step();
    @(negedge clk); chk("stl_wb1", 32'(sched_wb_vld), 0);
    step(); drive_idle();
    @(negedge clk);
    chk("stl_wb_vld", 32'(sched_wb_vld), 1);
    chk("stl_wb_src", 32'(sched_wb_src_div), 0);
    chk("stl_wb_id", 32'(sched_wb_id), 5);
    step();
    @(negedge clk); chk("stl_busy_after", 32'(sched_busy), 0);

    // Reset with three reservations outstanding.
    for (int i = 1; i <= 3; i++) begin
      step(); drive_idle();
      ex1_issue_vld = 1; ex1_issue_id = 3'(i);
      @(negedge clk); chk($sformatf("rst_seq_grant%0d", i), 32'(sched_issue_grant), 1);
    end
    step(); drive_idle();
    #1 rst_b = 0;
    #1;
    chk("arst_wb_vld", 32'(sched_wb_vld), 0);
    chk("arst_wb_id", 32'(sched_wb_id), 0);
    chk("arst_busy", 32'(sched_busy), 0);
    chk("arst_grant", 32'(sched_issue_grant), 0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_wb[%0d]", i), 32'(sched_wb_vld), 0);
      chk($sformatf("post_rst_busy[%0d]", i), 32'(sched_busy), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
